// File: rtl/w_bram_wr_ctrl_pkg.sv
// Shared definitions for the BRAM write-side controller: address width, depth, and FSM state encoding.
package w_bram_wr_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH = 11;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
  localparam int unsigned OCC_WIDTH  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } wr_state_e;

endpackage

// File: rtl/w_bram_occ_cnt.sv
// Occupancy up/down counter (words written, not yet popped) with a sticky underflow flag.
module w_bram_occ_cnt
  import w_bram_wr_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  output logic [OCC_WIDTH-1:0] occupancy,
  output logic [OCC_WIDTH-1:0] occ_next_c,
  output logic                 underflow_err
);

  logic underflow_set;

  // A pop with nothing stored is dropped; any accept in the same cycle still counts.
  always_comb begin
    occ_next_c    = occupancy;
    underflow_set = 1'b0;
    if (dec && (occupancy == '0)) begin
      underflow_set = 1'b1;
      if (inc) occ_next_c = occupancy + OCC_WIDTH'(1);
    end else if (inc && !dec) begin
      occ_next_c = occupancy + OCC_WIDTH'(1);
    end else if (dec && !inc) begin
      occ_next_c = occupancy - OCC_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      occupancy     <= '0;
      underflow_err <= 1'b0;
    end else begin
      occupancy <= occ_next_c;
      if (underflow_set) underflow_err <= 1'b1;
    end
  end

endmodule

// File: rtl/w_bram_wr_ctrl.sv
// BRAM port-A write controller: stream in, one-cycle-latency write strobe/data out, occupancy tracking.
// Optional W_BRAM_PARITY_EN widens DIN_A by one even-parity bit.
module w_bram_wr_ctrl
  import w_bram_wr_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  wr_enable,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  rd_pop,
  output logic                  WE_A,
`ifdef W_BRAM_PARITY_EN
  output logic [DATA_WIDTH:0]   DIN_A,
`else
  output logic [DATA_WIDTH-1:0] DIN_A,
`endif
  output logic                  w_bram_addr_en,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [OCC_WIDTH-1:0]  occupancy,
  output logic                  full,
  output logic                  underflow_err
);

  wr_state_e              state_q, state_d;
  logic                   s_ready_d, full_d;
  logic                   accept;
  logic                   we_q;
  logic [OCC_WIDTH-1:0]   occ_next;

  assign accept = s_valid && s_ready;

  w_bram_occ_cnt u_occ_cnt (
    .CLK           (CLK),
    .rst           (rst),
    .inc           (accept),
    .dec           (rd_pop),
    .occupancy     (occupancy),
    .occ_next_c    (occ_next),
    .underflow_err (underflow_err)
  );

  // Next state plus next values of s_ready/full, so both leave as plain registers.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (wr_enable) state_d = ST_RUN;
      ST_RUN: begin
        if (!wr_enable)                          state_d = ST_IDLE;
        else if (occ_next == OCC_WIDTH'(DEPTH))  state_d = ST_FULL;
      end
      ST_FULL: begin
        if (!wr_enable)                          state_d = ST_IDLE;
        else if (occ_next < OCC_WIDTH'(DEPTH))   state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    s_ready_d = (state_d == ST_RUN) && (occ_next < OCC_WIDTH'(DEPTH));
    full_d    = (occ_next == OCC_WIDTH'(DEPTH));
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      s_ready <= 1'b0;
      full    <= 1'b0;
      we_q    <= 1'b0;
      DIN_A   <= '0;
      wr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      s_ready <= s_ready_d;
      full    <= full_d;
      we_q    <= accept;
      if (accept) begin
`ifdef W_BRAM_PARITY_EN
        DIN_A <= {^s_data, s_data};
`else
        DIN_A <= s_data;
`endif
      end
      // Mirrors the external address counter: it steps at the end of each write cycle.
      if (we_q) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
    end
  end

  assign WE_A           = we_q;
  assign w_bram_addr_en = we_q;

endmodule

// File: doc/w_bram_wr_ctrl.md
# w_bram_wr_ctrl

Write-side controller that sits directly upstream of the port-A write-address counter. It accepts data words on a valid/ready stream and drives the BRAM port-A write strobe and data. It also drives the address counter's advance strobe, so the counter steps exactly once per word written. Occupancy is tracked against read-side pops, so the write pointer can never wrap onto words that have not yet been read.

## Interface
- DATA_WIDTH, 16, width of stream and BRAM data words
- DEPTH, 2**`ADDR_WIDTH (2048), BRAM words; fixed by the shared package, not overridden per instance
- CLK  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_enable  in  1  level; high permits acceptance of stream words
- s_valid  in  1  upstream word valid
- s_data  in  DATA_WIDTH  upstream word
- s_ready  out  1  controller can accept this cycle
- rd_pop  in  1  read side consumed one word this cycle
- WE_A  out  1  BRAM port-A write enable
- DIN_A  out  DATA_WIDTH (+1 with parity)  BRAM port-A write data
- w_bram_addr_en  out  1  advance strobe to the address counter
- wr_ptr  out  `ADDR_WIDTH  shadow of the counter's address, for debug and checking
- occupancy  out  `ADDR_WIDTH+1  words written and not yet popped, range 0..DEPTH
- full  out  1  occupancy == DEPTH
- underflow_err  out  1  sticky; rd_pop arrived while occupancy == 0

## Operation
- The FSM has three states, IDLE, RUN and FULL; reset state is IDLE.
- IDLE -> RUN on the first edge with wr_enable=1.
- RUN -> FULL on an edge where occupancy becomes DEPTH, i.e. an accept with no pop while occupancy == DEPTH-1.
- FULL -> RUN on an edge with rd_pop=1, when occupancy drops below DEPTH.
- RUN/FULL -> IDLE on any edge with wr_enable=0. A word already registered still issues its write in the following cycle.
- s_ready = (state==RUN) && (occupancy < DEPTH). It is decoded from registers only and has no combinational path from s_valid.
- Accept = s_valid && s_ready at a rising edge.
- Occupancy is updated at each edge as follows:
  - accept only: +1
  - pop only: -1
  - accept and pop together: unchanged
  - pop with occupancy 0: ignored, and underflow_err is set.
- wr_ptr increments on each issued write and wraps from DEPTH-1 (2047) to 0. It tracks the counter exactly.
- underflow_err is cleared only by reset.

## Timing
- All outputs are 0 after reset: s_ready, WE_A, DIN_A, w_bram_addr_en, wr_ptr, occupancy, full and underflow_err.
- rst is asserted asynchronously and released synchronously to CLK at integration level.
- Write latency is 1 cycle:
  - A word accepted at edge k has WE_A=1, w_bram_addr_en=1 and DIN_A=s_data held for the single cycle between edges k and k+1.
  - The address counter presents the write address during that cycle and advances at edge k+1.
- WE_A and w_bram_addr_en are the same register and are never unequal.
- Back-to-back accepts give one write per cycle at full throughput.
- Occupancy and full change at the accept edge, one cycle before the write lands. The read side must therefore pop only words whose write cycle has completed.
- s_ready falls in the cycle after the accept that fills the memory. No word is accepted beyond DEPTH.

## Configuration
- W_BRAM_PARITY_EN, when defined:
  - DIN_A is DATA_WIDTH+1 bits wide.
  - Bit DATA_WIDTH holds even parity (XOR reduction) of s_data, computed in the accept register stage. Latency is unchanged.
- When W_BRAM_PARITY_EN is undefined, DIN_A is exactly DATA_WIDTH bits and no parity logic exists.

## Structure
- `ADDR_WIDTH, the DEPTH derivation and the FSM state encodings (IDLE=2'd0, RUN=2'd1, FULL=2'd2) belong in package_fpga.v.
- The occupancy up/down counter, with its underflow flag, is a natural sub-module: w_bram_occ_cnt.

## Test plan
- Reset: hold rst=0 for 3 cycles with s_valid=1 -> all outputs 0, no WE_A pulse.
- Streaming: wr_enable=1, 10 consecutive words 0x0001..0x000A -> 10 WE_A cycles with DIN_A matching in order, each one cycle after its accept; wr_ptr=10, occupancy=10.
- Full and wrap:
  - Write 2048 words with no pops -> full=1, s_ready=0 and state FULL.
  - One rd_pop -> occupancy=2047 and s_ready=1; the next write occurs at wr_ptr=0 (wrap from 2047).
- Simultaneous accept and pop at occupancy 5 -> occupancy stays 5 and a write still issues.
- Underflow and disable:
  - rd_pop at occupancy 0 -> underflow_err=1 and it stays set; occupancy stays 0.
  - wr_enable dropped the cycle after an accept -> that word still writes, then s_ready=0.
- Mid-stream reset: rst asserted after 100 writes -> all outputs 0 immediately; after release, the first write is at wr_ptr=0 and the parity bit is correct with W_BRAM_PARITY_EN (0x0003 -> bit16=0, 0x0007 -> bit16=1).
